digit_serial_adder: RTL and testbench

Parametrised multi-cycle successor to the single-bit full adder. Adds two WIDTH-bit operands plus a carry-in. Each clock it processes one DIGIT-bit slice, least-significant slice first, through a registered carry chain. Operands enter on a valid/ready handshake and results leave on one. Intended as the shared arithmetic block for later accumulator/ALU labs, where area matters more than single-cycle latency.

---
 rtl/digit_serial_adder_pkg.sv | 27 ++
 rtl/digit_serial_adder_digit_adder.sv | 36 +++
 rtl/full_adder.sv | 18 +
 rtl/digit_serial_adder.sv | 111 +++++++++++
 tb/tb_digit_serial_adder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/digit_serial_adder_pkg.sv
// ==== digit_serial_adder_pkg : FSM encodings and width helpers for the digit-serial adder
// ==== rev 1.0
`default_nettype none

package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A one-step operation still keeps a 1-bit counter.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? clog2(steps) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_serial_adder_digit_adder.sv
// ==== digit_adder : combinational DIGIT-bit ripple chain of full_adder cells
// ==== rev 1.0
`default_nettype none

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_top
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .s    (s[i]),
      .cout (w_c[i+1])
    );
  end

  assign cout  = w_c[DIGIT];
  // Carry into the top bit; on the last slice this feeds the overflow flag.
  assign c_top = w_c[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ==== full_adder : single-bit full adder cell
// ==== rev 1.0
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/digit_serial_adder.sv
// ==== digit_serial_adder : WIDTH-bit adder processing DIGIT bits per clock, valid/ready in and out
// ==== rev 1.0
`default_nettype none

module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STEPS   = WIDTH / DIGIT;
  localparam int C_CNT_W = cnt_width(STEPS);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(STEPS - 1);

  if ((WIDTH < 1) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_param
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t             r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry_out;
  logic               r_overflow;

  logic [DIGIT-1:0]   w_x_slice;
  logic [DIGIT-1:0]   w_y_slice;
  logic [DIGIT-1:0]   w_s;
  logic               w_c;
  logic               w_c_top;

  assign w_x_slice = r_x[r_cnt*DIGIT +: DIGIT];
  assign w_y_slice = r_y[r_cnt*DIGIT +: DIGIT];

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a     (w_x_slice),
    .b     (w_y_slice),
    .cin   (r_carry),
    .s     (w_s),
    .cout  (w_c),
    .c_top (w_c_top)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= x;
            r_y     <= y;
            r_carry <= carry_in;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[r_cnt*DIGIT +: DIGIT] <= w_s;
          r_carry                     <= w_c;
          if (r_cnt == C_LAST) begin
            r_carry_out <= w_c;
            r_overflow  <= w_c_top ^ w_c;
            r_cnt       <= '0;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
// ==== tb_digit_serial_adder : directed and random checks of four digit_serial_adder configurations
// ==== rev 1.0
`default_nettype none

module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance index: 0 = 16/4, 1 = 1/1, 2 = 16/16, 3 = 16/2
  int W  [4] = '{16, 1, 16, 16};
  int ST [4] = '{4, 1, 1, 8};

  logic        iv   [4];
  logic        ordy [4];
  logic        cin  [4];
  logic [15:0] xa   [4];
  logic [15:0] ya   [4];

  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic        co0, co1, co2, co3;
  logic        of0, of1, of2, of3;
  logic [15:0] s0, s2, s3;
  logic        s1;

  int total = 0;
  int bad   = 0;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .x(xa[0]), .y(ya[0]),
    .carry_in(cin[0]), .out_valid(ov0), .out_ready(ordy[0]), .sum(s0), .carry_out(co0), .overflow(of0));
  digit_serial_adder #(.WIDTH(1), .DIGIT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .x(xa[1][0]), .y(ya[1][0]),
    .carry_in(cin[1]), .out_valid(ov1), .out_ready(ordy[1]), .sum(s1), .carry_out(co1), .overflow(of1));
  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .x(xa[2]), .y(ya[2]),
    .carry_in(cin[2]), .out_valid(ov2), .out_ready(ordy[2]), .sum(s2), .carry_out(co2), .overflow(of2));
  digit_serial_adder #(.WIDTH(16), .DIGIT(2)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir3), .x(xa[3]), .y(ya[3]),
    .carry_in(cin[3]), .out_valid(ov3), .out_ready(ordy[3]), .sum(s3), .carry_out(co3), .overflow(of3));

  // Observed result packed as {overflow, carry_out, sum}.
  function automatic logic [17:0] res(input int k);
    case (k)
      0:       return {of0, co0, s0};
      1:       return {of1, co1, 15'b0, s1};
      2:       return {of2, co2, s2};
      default: return {of3, co3, s3};
    endcase
  endfunction

  function automatic logic rdy(input int k);
    case (k)
      0:       return ir0;
      1:       return ir1;
      2:       return ir2;
      default: return ir3;
    endcase
  endfunction

  function automatic logic vld(input int k);
    case (k)
      0:       return ov0;
      1:       return ov1;
      2:       return ov2;
      default: return ov3;
    endcase
  endfunction

  // Plain-arithmetic reference: modular sum, carry out of the top bit, signed overflow.
  function automatic logic [17:0] model(input int k, input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    longint unsigned m, t, s;
    logic sa, sb, ss, co, ovf;
    m   = (64'd1 << W[k]) - 64'd1;
    t   = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
    s   = t & m;
    co  = t[W[k]];
    sa  = a[W[k]-1];
    sb  = b[W[k]-1];
    ss  = s[W[k]-1];
    ovf = (sa == sb) && (ss != sa);
    return {ovf, co, s[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands at a negedge; returns at the negedge just after the accepting edge.
  task automatic start(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(rdy(k)), 32'd1);
    iv[k] = 1'b1; xa[k] = a; ya[k] = b; cin[k] = c;
    @(negedge clk);
    iv[k] = 1'b0; xa[k] = 16'($urandom); ya[k] = 16'($urandom); cin[k] = 1'($urandom);
  endtask

  task automatic wait_res(input int k, input logic [17:0] exp);
    int lat;
    lat = 0;
    while (!vld(k) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(ST[k]));
    chk("result", 32'(res(k)), 32'(exp));
  endtask

  task automatic release_res(input int k);
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    chk("in_ready_after_release", 32'(rdy(k)), 32'd1);
    chk("out_valid_after_release", 32'(vld(k)), 32'd0);
  endtask

  task automatic op(input int k, input logic [15:0] a, input logic [15:0] b, input logic c,
                    input logic [17:0] exp);
    start(k, a, b, c);
    wait_res(k, exp);
    release_res(k);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; cin[k] = 1'b0; xa[k] = '0; ya[k] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_in_ready", 32'(rdy(k)), 32'd1);
      chk("reset_out_valid", 32'(vld(k)), 32'd0);
      chk("reset_result", 32'(res(k)), 32'd0);
    end
    rst_n = 1'b1;

    // Directed results for the 16/4 configuration
    op(0, 16'h1234, 16'h4321, 1'b0, 18'h05555);
    op(0, 16'hFFFF, 16'h0001, 1'b0, 18'h10000);
    op(0, 16'h7FFF, 16'h0001, 1'b0, 18'h28000);
    op(0, 16'h0000, 16'h0000, 1'b1, 18'h00001);

    // Backpressure: result held, new operands refused until released
    start(0, 16'h1111, 16'h2222, 1'b0);
    wait_res(0, 18'h03333);
    iv[0] = 1'b1; xa[0] = 16'hAAAA; ya[0] = 16'h5555; cin[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_result_held", 32'(res(0)), 32'h03333);
      chk("bp_in_ready", 32'(rdy(0)), 32'd0);
      chk("bp_out_valid", 32'(vld(0)), 32'd1);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("bp_in_ready_after", 32'(rdy(0)), 32'd1);
    @(negedge clk);
    iv[0] = 1'b0;
    wait_res(0, 18'h10000);
    release_res(0);

    // Asynchronous reset while the counter sits at 2
    start(0, 16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(rdy(0)), 32'd1);
    chk("rst_mid_out_valid", 32'(vld(0)), 32'd0);
    chk("rst_mid_result", 32'(res(0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_out_valid", 32'(vld(0)), 32'd0);
    end
    op(0, 16'h0F0F, 16'h00F1, 1'b0, 18'h01000);

    // 1-bit configuration: full-adder truth table from its Boolean definition
    for (int v = 0; v < 8; v++) begin
      logic a, b, c, s, co;
      a = v[2]; b = v[1]; c = v[0];
      s = a ^ b ^ c;
      co = (a & b) | (c & (a ^ b));
      op(1, {15'b0, a}, {15'b0, b}, c, {c ^ co, co, 15'b0, s});
    end

    // Random back-to-back operations
    for (int n = 0; n < 20; n++) begin
      logic [15:0] a, b;
      logic c;
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      op(2, a, b, c, model(2, a, b, c));
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      op(3, a, b, c, model(3, a, b, c));
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      op(0, a, b, c, model(0, a, b, c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
